// File: rtl/llsc_sc_unit_pkg.sv
// Shared types and constants for the LL/SC store-conditional unit.
// State encodings and polarity constants used across the slice.
package llsc_sc_unit_pkg;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_STORE = 2'd1,
    SC_DONE  = 2'd2
  } sc_state_e;

  localparam logic RstEnable   = 1'b0;
  localparam logic WriteEnable = 1'b1;

endpackage

// File: rtl/llsc_link_reg.sv
// LLbit and link address register.
// Update priority: flush, matching snoop, SC clear, LL set.
module llsc_link_reg
  import llsc_sc_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int GRAN_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              sc_clr,
  input  logic              ll_set,
  input  logic [ADDR_W-1:0] ll_addr,
  output logic              llbit,
  output logic [ADDR_W-1:0] link_addr,
  output logic              snoop_hit
);

  assign snoop_hit = (snoop_we == WriteEnable) &&
    (snoop_addr[ADDR_W-1:GRAN_LSB] ==
     link_addr[ADDR_W-1:GRAN_LSB]);

  // link_addr survives flush/snoop; only LLbit is cleared
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      llbit     <= 1'b0;
      link_addr <= '0;
    end else if (flush) begin
      llbit <= 1'b0;
    end else if (snoop_hit) begin
      llbit <= 1'b0;
    end else if (sc_clr) begin
      llbit <= 1'b0;
    end else if (ll_set) begin
      llbit     <= 1'b1;
      link_addr <= ll_addr;
    end
  end

endmodule

// File: rtl/llsc_sc_unit.sv
// Store-conditional resolver: checks the link, issues the
// conditional store over req/ack, and reports the SC result.
module llsc_sc_unit
  import llsc_sc_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int GRAN_LSB = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ll_valid,
  input  logic [ADDR_W-1:0]   ll_addr,
  input  logic                sc_valid,
  input  logic [ADDR_W-1:0]   sc_addr,
  input  logic [DATA_W-1:0]   sc_data,
  input  logic [DATA_W/8-1:0] sc_sel,
  input  logic                flush,
  input  logic                snoop_we,
  input  logic [ADDR_W-1:0]   snoop_addr,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic                mem_ack,
  output logic                stall_req,
  output logic                sc_done,
  output logic                sc_result,
  output logic                LLbit_o,
  output logic [ADDR_W-1:0]   link_addr_o
);

  sc_state_e state, state_nxt;
  logic      ok_q;
  logic      drop_q;
  logic      snoop_hit;
  logic      sc_go;
  logic      sc_pass;
  logic      in_idle;
  logic      in_store;

  assign in_idle  = (state == SC_IDLE);
  assign in_store = (state == SC_STORE);
  assign sc_go    = in_idle & sc_valid & ~flush;
  assign sc_pass  = LLbit_o & ~snoop_hit &
    (sc_addr[ADDR_W-1:GRAN_LSB] ==
     link_addr_o[ADDR_W-1:GRAN_LSB]);

  llsc_link_reg #(
    .ADDR_W   (ADDR_W),
    .GRAN_LSB (GRAN_LSB)
  ) u_link (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .snoop_we   (snoop_we),
    .snoop_addr (snoop_addr),
    .sc_clr     (sc_go),
    .ll_set     (ll_valid & in_idle),
    .ll_addr    (ll_addr),
    .llbit      (LLbit_o),
    .link_addr  (link_addr_o),
    .snoop_hit  (snoop_hit)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      SC_IDLE: begin
        if (sc_go)
          state_nxt = sc_pass ? SC_STORE : SC_DONE;
      end
      SC_STORE: begin
        if (mem_ack)
          state_nxt = (drop_q | flush) ? SC_IDLE : SC_DONE;
      end
      SC_DONE: state_nxt = SC_IDLE;
      default: state_nxt = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state <= SC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // drop_q remembers a flush seen while the store was in flight
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      ok_q      <= 1'b0;
      drop_q    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
    end else if (sc_go) begin
      ok_q   <= sc_pass;
      drop_q <= 1'b0;
      if (sc_pass) begin
        mem_addr  <= sc_addr;
        mem_wdata <= sc_data;
        mem_sel   <= sc_sel;
      end
    end else if (in_store && flush) begin
      drop_q <= 1'b1;
    end
  end

  assign mem_req   = in_store;
  assign stall_req = sc_go | in_store;
  assign sc_done   = (state == SC_DONE) & ~flush;
  assign sc_result = sc_done & ok_q;

endmodule
